id_ex_stage: RTL

ID/EX pipeline register with integrated load-use hazard detection and branch flush control for the 5-stage RISC-V core. It captures the decode-stage control bundle (`RegWrite`, `ALUSrc`, `MemWrite`, `ResultSrc`, `Branch`, `ALUControl`) and operands, and presents them to Execute one cycle later. It generates stall and flush requests for Fetch and Decode, inserts bubbles, and keeps saturating stall and flush event counters.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/load_use_detect.sv | 17 +
 rtl/id_ex_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared opcodes, ALU encodings and widths for the 5-stage core
package pipeline_pkg;
  localparam int DEF_XLEN = 32;
  localparam int REG_W = 5;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a Decode instruction that reads the destination of a load in Execute
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             i_valid_e,
  input  logic             i_load_e,
  input  logic [REG_W-1:0] i_rd_e,
  input  logic [REG_W-1:0] i_rs1_d,
  input  logic [REG_W-1:0] i_rs2_d,
  input  logic             i_valid_d,
  input  logic             i_pcsrc_e,
  output logic             o_lw_stall
);
  // rs2 is compared for every format; an occasional spurious stall is harmless
  assign o_lw_stall = i_valid_e & i_load_e & (i_rd_e != '0) &
                      ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d)) & i_valid_d & ~i_pcsrc_e;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with load-use stall, branch flush and saturating event counters
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD,
  input  logic             ALUSrcD,
  input  logic             MemWriteD,
  input  logic             ResultSrcD,
  input  logic             BranchD,
  input  logic [2:0]       ALUControlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             ValidD,
  input  logic             PCSrcE,
  output logic             RegWriteE,
  output logic             ALUSrcE,
  output logic             MemWriteE,
  output logic             ResultSrcE,
  output logic             BranchE,
  output logic [2:0]       ALUControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  logic w_lw_stall;
  logic w_bubble;
  load_use_detect u_lud (
    .i_valid_e(ValidE),
    .i_load_e(ResultSrcE),
    .i_rd_e(RdE),
    .i_rs1_d(Rs1D),
    .i_rs2_d(Rs2D),
    .i_valid_d(ValidD),
    .i_pcsrc_e(PCSrcE),
    .o_lw_stall(w_lw_stall)
  );
  assign w_bubble = PCSrcE | w_lw_stall;
  assign StallF = w_lw_stall;
  assign StallD = w_lw_stall;
  assign FlushD = PCSrcE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE} <= '0;
      ALUControlE <= '0;
      {RD1E, RD2E, ImmExtE, PCE} <= '0;
      {Rs1E, Rs2E, RdE} <= '0;
    end else if (w_bubble) begin
      {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE} <= '0;
      ALUControlE <= '0;
      RdE <= '0;
    end else begin
      // an empty Decode slot enters Execute with every control bit cleared
      {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE} <=
        {RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD} & {5{ValidD}};
      ALUControlE <= ValidD ? ALUControlD : 3'b000;
      ValidE <= ValidD;
      {RD1E, RD2E, ImmExtE, PCE} <= {RD1D, RD2D, ImmExtD, PCD};
      {Rs1E, Rs2E, RdE} <= {Rs1D, Rs2D, RdD};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (w_lw_stall && !(&StallCnt)) StallCnt <= StallCnt + 1'b1;
      if (PCSrcE && !(&FlushCnt)) FlushCnt <= FlushCnt + 1'b1;
    end
  end
endmodule
